// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module : ps2_rx_fifo
// Brief  : PS/2 device-to-host receiver with frame checking, sticky error
//          flags and a show-ahead output FIFO.
// Rev    : 1.0
// ============================================================================
module ps2_rx_fifo #(
    parameter int FREQ     = 12500,
    parameter int PS2_FREQ = 10,
    parameter int TIMEOUT  = FREQ / PS2_FREQ,
    parameter int FILT     = 2,
    parameter int FIFO_AW  = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    input  logic               rd,
    input  logic               clr_err,
    output logic [7:0]         code,
    output logic               empty,
    output logic [FIFO_AW:0]   count,
    output logic               busy,
    output logic               err_parity,
    output logic               err_frame,
    output logic               err_timeout,
    output logic               overflow
);
    localparam int              TW       = $clog2(TIMEOUT + 1);
    localparam int              CW       = FIFO_AW + 1;
    localparam int              DEPTH    = 1 << FIFO_AW;
    localparam logic [TW-1:0]   TMAX     = TW'(TIMEOUT);
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECV   = 2'd1,
        S_CHECK  = 2'd2,
        S_RESYNC = 2'd3
    } state_t;

    logic [1:0]          r_clk_sync;
    logic [1:0]          r_dat_sync;
    logic [2*FILT-1:0]   r_hist;
    logic [TW-1:0]       r_timer;
    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_bitcnt;
    logic [9:0]          r_shift;
    logic [7:0]          r_mem [DEPTH];
    logic [CW-1:0]       r_wptr;
    logic [CW-1:0]       r_rptr;
    logic                r_err_par, r_err_frm, r_err_to, r_ovf;

    logic w_clk_s, w_dat_s, w_fall, w_rise, w_sat, w_quiet, w_stuck;
    logic w_start, w_shift, w_push_req, w_set_par, w_set_frm, w_set_to;
    logic w_full, w_pop, w_wr, w_set_ovf;

    // Clock line idles high, so sync and history preset to 1 on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_hist     <= '1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
            r_hist     <= {r_hist[2*FILT-2:0], r_clk_sync[1]};
        end
    end

    assign w_clk_s = r_clk_sync[1];
    assign w_dat_s = r_dat_sync[1];
    assign w_fall  = (r_hist[2*FILT-1:FILT] == '1) && (r_hist[FILT-1:0] == '0);
    assign w_rise  = (r_hist[2*FILT-1:FILT] == '0) && (r_hist[FILT-1:0] == '1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_timer <= '0;
        else if (w_fall || w_rise)
            r_timer <= '0;
        else if (r_timer != TMAX)
            r_timer <= r_timer + TW'(1);
    end

    // An edge in the same cycle logically clears the timer, so it masks quiet/stuck.
    assign w_sat   = (r_timer == TMAX) && !w_fall && !w_rise;
    assign w_quiet = w_sat && w_clk_s;
    assign w_stuck = w_sat && !w_clk_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift     = 1'b0;
        w_push_req  = 1'b0;
        w_set_par   = 1'b0;
        w_set_frm   = 1'b0;
        w_set_to    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    if (w_dat_s) begin
                        w_set_frm   = 1'b1;
                        w_state_nxt = S_RESYNC;
                    end else begin
                        w_start     = 1'b1;
                        w_state_nxt = S_RECV;
                    end
                end
            end
            S_RECV: begin
                if (w_fall) begin
                    w_shift = 1'b1;
                    if (r_bitcnt == 4'd10)
                        w_state_nxt = S_CHECK;
                end else if (w_quiet || w_stuck) begin
                    w_set_to    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_CHECK: begin
                w_state_nxt = S_IDLE;
                if (!r_shift[9])
                    w_set_frm = 1'b1;
                else if (!(^r_shift[8:0]))
                    w_set_par = 1'b1;
                else
                    w_push_req = 1'b1;
            end
            S_RESYNC: begin
                if (w_quiet)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (r_state != S_RECV && w_stuck)
            w_set_to = 1'b1;
    end

    // Shift register layout after 10 shifts: [7:0] data, [8] parity, [9] stop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bitcnt <= '0;
            r_shift  <= '0;
        end else if (w_start) begin
            r_bitcnt <= 4'd1;
        end else if (w_shift) begin
            r_bitcnt <= r_bitcnt + 4'd1;
            r_shift  <= {w_dat_s, r_shift[9:1]};
        end
    end

    assign count     = r_wptr - r_rptr;
    assign empty     = (count == '0);
    assign w_full    = (count == FULL_CNT);
    assign w_pop     = rd && !empty;
    assign w_wr      = w_push_req && (!w_full || w_pop);
    assign w_set_ovf = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + CW'(1);
            if (w_pop)
                r_rptr <= r_rptr + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wptr[FIFO_AW-1:0]] <= r_shift[7:0];
    end

    assign code = empty ? 8'h00 : r_mem[r_rptr[FIFO_AW-1:0]];
    assign busy = (r_state != S_IDLE);

    // A set condition wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_par <= 1'b0;
            r_err_frm <= 1'b0;
            r_err_to  <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_err_par <= w_set_par | (r_err_par & ~clr_err);
            r_err_frm <= w_set_frm | (r_err_frm & ~clr_err);
            r_err_to  <= w_set_to  | (r_err_to  & ~clr_err);
            r_ovf     <= w_set_ovf | (r_ovf     & ~clr_err);
        end
    end

    assign err_parity  = r_err_par;
    assign err_frame   = r_err_frm;
    assign err_timeout = r_err_to;
    assign overflow    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_ps2_rx_fifo
// Brief  : Directed frames into ps2_rx_fifo; a monitor pops the FIFO and
//          compares against a queue of expected bytes.
// Rev    : 1.0
// ============================================================================
module tb_ps2_rx_fifo;
    localparam int FREQ     = 1000;
    localparam int PS2_FREQ = 10;
    localparam int TIMEOUT  = FREQ / PS2_FREQ;
    localparam int FILT     = 2;
    localparam int FIFO_AW  = 3;
    localparam int HALF     = 40;
    localparam int QTR      = 20;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               ps2_clk = 1'b1;
    logic               ps2_data = 1'b1;
    logic               clr_err = 1'b0;
    logic               mon_rd = 1'b0;
    logic               tst_rd = 1'b0;
    logic               drain_en = 1'b0;
    logic               rd;
    logic [7:0]         code;
    logic               empty;
    logic [FIFO_AW:0]   count;
    logic               busy, err_parity, err_frame, err_timeout, overflow;

    int                 vectors = 0;
    int                 miscompares = 0;
    logic [7:0]         exp_q[$];
    logic [7:0]         mon_exp;

    assign rd = mon_rd | tst_rd;

    ps2_rx_fifo #(
        .FREQ(FREQ), .PS2_FREQ(PS2_FREQ), .TIMEOUT(TIMEOUT), .FILT(FILT), .FIFO_AW(FIFO_AW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rd(rd), .clr_err(clr_err), .code(code), .empty(empty), .count(count),
        .busy(busy), .err_parity(err_parity), .err_frame(err_frame),
        .err_timeout(err_timeout), .overflow(overflow)
    );

    always #500 clk = ~clk;

    // Pops whenever draining is enabled and the FIFO shows a byte.
    always @(negedge clk) begin
        if (drain_en && reset_n && !empty) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pop_unexpected: got %02h, expected no byte", code);
            end else begin
                mon_exp = exp_q.pop_front();
                if (code !== mon_exp) begin
                    miscompares++;
                    $display("FAIL pop_code: got %02h, expected %02h", code, mon_exp);
                end
            end
            mon_rd = 1'b1;
        end else begin
            mon_rd = 1'b0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input bit bad_par,
                                       input bit start, input bit stop);
        return {stop, (~^d) ^ bad_par, d, start};
    endfunction

    // Device timing: data set while clock high, then clock low/high.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input bit rd_at_check);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            cyc(QTR);
            ps2_clk = 1'b0;
            if (rd_at_check && i == 10) begin
                cyc(5);
                tst_rd = 1'b1;
                cyc(1);
                tst_rd = 1'b0;
                cyc(HALF - 6);
            end else begin
                cyc(HALF);
            end
            ps2_clk = 1'b1;
            cyc(QTR);
        end
    endtask

    task automatic good(input logic [7:0] d, input bit expect_stored);
        if (expect_stored)
            exp_q.push_back(d);
        send_bits(mk(d, 1'b0, 1'b0, 1'b1), 11, 1'b0);
        cyc(30);
    endtask

    task automatic clear_flags();
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
    endtask

    task automatic wait_drained();
        int n = 0;
        while ((exp_q.size() != 0 || !empty) && n < 500) begin
            cyc(1);
            n++;
        end
        chk("drained", {31'd0, (exp_q.size() == 0) && empty}, 32'd1);
    endtask

    initial begin
        #90_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc(5);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_code", code, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {err_parity, err_frame, err_timeout, overflow}, 4'b0000);
        reset_n = 1'b1;
        cyc(10);

        // Good frame 0x1C held in the FIFO, then popped
        good(8'h1C, 1'b1);
        chk("good_code", code, 8'h1C);
        chk("good_count", count, 1);
        chk("good_empty", empty, 0);
        chk("good_flags", {err_parity, err_frame, err_timeout, overflow}, 4'b0000);
        drain_en = 1'b1;
        cyc(3);
        chk("pop_empty", empty, 1);

        // Parity error, clear, then good 0xF0
        send_bits(mk(8'h1C, 1'b1, 1'b0, 1'b1), 11, 1'b0);
        cyc(30);
        chk("par_flag", err_parity, 1);
        chk("par_count", count, 0);
        chk("par_frame_clean", err_frame, 0);
        clear_flags();
        chk("par_cleared", err_parity, 0);
        good(8'hF0, 1'b1);
        wait_drained();

        // Bad start bit: RESYNC until quiet, then good 0x5A
        send_bits(mk(8'h5A, 1'b0, 1'b1, 1'b1), 11, 1'b0);
        chk("start_err", err_frame, 1);
        chk("resync_busy", busy, 1);
        cyc(TIMEOUT);
        chk("resync_done", busy, 0);
        clear_flags();
        good(8'h5A, 1'b1);
        wait_drained();

        // Bad stop bit
        send_bits(mk(8'h33, 1'b0, 1'b0, 1'b0), 11, 1'b0);
        cyc(30);
        chk("stop_err", err_frame, 1);
        chk("stop_count", count, 0);
        clear_flags();

        // Stall high after 5 bits
        send_bits(mk(8'hA5, 1'b0, 1'b0, 1'b1), 5, 1'b0);
        cyc(TIMEOUT - 30);
        chk("stall_busy_before", busy, 1);
        chk("stall_flag_before", err_timeout, 0);
        cyc(30);
        chk("stall_busy_after", busy, 0);
        chk("stall_flag_after", err_timeout, 1);
        clear_flags();
        good(8'h6B, 1'b1);
        wait_drained();

        // Clock held low mid-frame
        send_bits(mk(8'hA5, 1'b0, 1'b0, 1'b1), 3, 1'b0);
        ps2_clk = 1'b0;
        cyc(TIMEOUT + 20);
        chk("stuck_flag", err_timeout, 1);
        chk("stuck_busy", busy, 0);
        ps2_clk = 1'b1;
        cyc(30);
        clear_flags();
        chk("stuck_cleared", err_timeout, 0);
        good(8'h3C, 1'b1);
        wait_drained();

        // Overflow: 9 frames, 9th dropped
        drain_en = 1'b0;
        for (int i = 1; i <= 9; i++)
            good(8'(i), i <= 8);
        chk("ovf_count", count, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", code, 8'h01);
        clear_flags();
        drain_en = 1'b1;
        wait_drained();

        // Pointer wrap with interleaved reads
        for (int i = 0; i < 8; i++)
            good(8'h10 + 8'(i), 1'b1);
        wait_drained();

        // Full FIFO, rd asserted in the CHECK cycle
        drain_en = 1'b0;
        for (int i = 0; i < 8; i++)
            good(8'h20 + 8'(i), 1'b1);
        chk("full_count", count, 8);
        chk("full_head", code, 8'h20);
        void'(exp_q.pop_front());
        exp_q.push_back(8'h28);
        send_bits(mk(8'h28, 1'b0, 1'b0, 1'b1), 11, 1'b1);
        cyc(30);
        chk("fullrd_count", count, 8);
        chk("fullrd_ovf", overflow, 0);
        chk("fullrd_head", code, 8'h21);
        drain_en = 1'b1;
        wait_drained();

        // Reset mid-frame with a byte stored and a flag set
        drain_en = 1'b0;
        good(8'h77, 1'b1);
        send_bits(mk(8'h1C, 1'b1, 1'b0, 1'b1), 11, 1'b0);
        cyc(30);
        send_bits(mk(8'h1C, 1'b0, 1'b0, 1'b1), 6, 1'b0);
        chk("mid_busy", busy, 1);
        chk("mid_count", count, 1);
        reset_n = 1'b0;
        #1;
        chk("mrst_count", count, 0);
        chk("mrst_empty", empty, 1);
        chk("mrst_code", code, 8'h00);
        chk("mrst_busy", busy, 0);
        chk("mrst_flags", {err_parity, err_frame, err_timeout, overflow}, 4'b0000);
        exp_q.delete();
        cyc(5);
        reset_n = 1'b1;
        cyc(10);
        drain_en = 1'b1;
        good(8'h1C, 1'b1);
        wait_drained();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
